// File: rtl/duty_ramp_controller_if.sv
// duty_ramp_controller_if: speed/direction command handshake into the ramp controller.
interface duty_ramp_controller_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_duty;
    logic       cmd_dir;
    modport master (output cmd_valid, cmd_duty, cmd_dir, input cmd_ready);
    modport slave (input cmd_valid, cmd_duty, cmd_dir, output cmd_ready);
endinterface

// File: rtl/duty_ramp_controller.sv
// duty_ramp_controller: slew-limited, PWM-period-aligned duty/direction sequencer with dead time and estop.
module duty_ramp_controller #(
    parameter int RAMP_PERIODS = 4,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                  clk_3125KHz,
    input  logic                  reset,
    duty_ramp_controller_if.slave cmd,
    input  logic                  estop,
    output logic [3:0]            duty_cycle,
    output logic                  motor_dir,
    output logic                  at_target
);
    typedef enum logic [2:0] {IDLE, RAMP, STOP_RAMP, DEAD, ESTOP} state_t;
    localparam logic [7:0] STEP_LAST = 8'(RAMP_PERIODS - 1);
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_PERIODS - 1);
    // an acceptance on a tick counts that tick as the first one of the ramp latency
    localparam logic [7:0] STEP_START = (RAMP_PERIODS > 1) ? 8'd1 : 8'd0;

    state_t     state_q, state_d;
    logic [3:0] period_cnt_q, period_cnt_d;
    logic [7:0] step_cnt_q, step_cnt_d;
    logic [7:0] dead_cnt_q, dead_cnt_d;
    logic [3:0] target_duty_q, target_duty_d;
    logic       target_dir_q, target_dir_d;
    logic [3:0] duty_cycle_q, duty_cycle_d;
    logic       motor_dir_q, motor_dir_d;
    logic       at_target_q, at_target_d;
    logic       tick, step, accept, dir_diff, dead_exit;
    logic [3:0] goal;

    assign cmd.cmd_ready = !reset && state_q != ESTOP;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign tick          = period_cnt_q == 4'hf;
    assign step          = tick && step_cnt_q == STEP_LAST;
    assign dead_exit     = tick && dead_cnt_q == DEAD_LAST;
    assign dir_diff      = target_dir_q != motor_dir_q;
    assign goal          = dir_diff ? 4'd0 : target_duty_q;

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state_q       <= IDLE;
            period_cnt_q  <= '0;
            step_cnt_q    <= '0;
            dead_cnt_q    <= '0;
            target_duty_q <= '0;
            target_dir_q  <= 1'b0;
            duty_cycle_q  <= '0;
            motor_dir_q   <= 1'b0;
            at_target_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            step_cnt_q    <= step_cnt_d;
            dead_cnt_q    <= dead_cnt_d;
            target_duty_q <= target_duty_d;
            target_dir_q  <= target_dir_d;
            duty_cycle_q  <= duty_cycle_d;
            motor_dir_q   <= motor_dir_d;
            at_target_q   <= at_target_d;
        end
    end

    always_comb begin
        duty_cycle_d = duty_cycle_q;
        if ((state_q == RAMP || state_q == STOP_RAMP) && step && duty_cycle_q != goal)
            duty_cycle_d = duty_cycle_q < goal ? duty_cycle_q + 4'd1 : duty_cycle_q - 4'd1;
        state_d = dir_diff ? (duty_cycle_d == 4'd0 ? DEAD : STOP_RAMP)
                           : (duty_cycle_d == target_duty_q ? IDLE : RAMP);
        if (state_q == DEAD)
            state_d = !dead_exit ? DEAD : target_duty_q == 4'd0 ? IDLE : RAMP;
        if (state_q == ESTOP)
            state_d = IDLE;
        if (estop) begin
            state_d      = ESTOP;
            duty_cycle_d = 4'd0;
        end
    end

    always_comb begin
        period_cnt_d  = period_cnt_q + 4'd1;
        step_cnt_d    = !tick ? step_cnt_q : step_cnt_q == STEP_LAST ? 8'd0 : step_cnt_q + 8'd1;
        if (accept && state_q == IDLE)
            step_cnt_d = tick ? STEP_START : 8'd0;
        dead_cnt_d    = state_q != DEAD ? 8'd0 : tick ? dead_cnt_q + 8'd1 : dead_cnt_q;
        if (state_q == ESTOP) begin
            step_cnt_d = 8'd0;
            dead_cnt_d = 8'd0;
        end
        target_duty_d = estop ? 4'd0 : accept ? cmd.cmd_duty : target_duty_q;
        target_dir_d  = (accept && !estop) ? cmd.cmd_dir : target_dir_q;
        motor_dir_d   = (!estop && state_q == DEAD && dead_exit) ? target_dir_q : motor_dir_q;
        at_target_d   = state_d == IDLE;
    end

    assign duty_cycle = duty_cycle_q;
    assign motor_dir  = motor_dir_q;
    assign at_target  = at_target_q;
endmodule

// File: tb/tb_duty_ramp_controller.sv
// tb_duty_ramp_controller: scenario tasks with a duty-step scoreboard and a period-phase model.
module tb_duty_ramp_controller;
    logic       clk;
    logic       reset;
    logic       estop;
    logic [3:0] duty_cycle;
    logic       motor_dir;
    logic       at_target;
    int         cmp;
    int         err;
    int         pc;
    logic [3:0] exp_q[$];

    duty_ramp_controller_if bus();

    duty_ramp_controller #(.RAMP_PERIODS(4), .DEAD_PERIODS(2)) dut (
        .clk_3125KHz(clk),
        .reset(reset),
        .cmd(bus),
        .estop(estop),
        .duty_cycle(duty_cycle),
        .motor_dir(motor_dir),
        .at_target(at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", cmp);
        $fatal(1, "watchdog");
    end

    task automatic step_clk();
        logic r;
        r = reset;
        @(posedge clk);
        pc = r ? 0 : (pc + 1) % 16;
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic dr);
        bus.cmd_valid = 1'b1;
        bus.cmd_duty  = d;
        bus.cmd_dir   = dr;
        step_clk();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step_clk();
        cmp++; if (bus.cmd_ready !== 1'b0) begin err++; $display("FAIL reset_ready: got %b want 0", bus.cmd_ready); end
        reset = 1'b0;
        step_clk();
        cmp++; if (duty_cycle !== 4'd0) begin err++; $display("FAIL reset_duty: got %0d want 0", duty_cycle); end
        cmp++; if (motor_dir !== 1'b0) begin err++; $display("FAIL reset_dir: got %b want 0", motor_dir); end
        cmp++; if (at_target !== 1'b1) begin err++; $display("FAIL reset_at_target: got %b want 1", at_target); end
        cmp++; if (bus.cmd_ready !== 1'b1) begin err++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_ramp();
        int pa, k;
        logic first;
        logic [3:0] prev, e;
        for (int i = 1; i <= 8; i++) exp_q.push_back(4'(i));
        pa = pc;
        send(4'd8, 1'b0);
        prev = duty_cycle; k = 0; first = 1'b1;
        for (int n = 0; n < 1200 && exp_q.size() > 0; n++) begin
            step_clk();
            k++;
            if (duty_cycle !== prev) begin
                e = exp_q.pop_front();
                cmp++; if (duty_cycle !== e) begin err++; $display("FAIL ramp_duty: got %0d want %0d", duty_cycle, e); end
                cmp++; if (k != (first ? 63 - pa : 64)) begin err++; $display("FAIL ramp_interval: got %0d clocks want %0d", k, first ? 63 - pa : 64); end
                cmp++; if (pc != 0) begin err++; $display("FAIL ramp_align: period phase %0d want 0", pc); end
                cmp++; if (motor_dir !== 1'b0) begin err++; $display("FAIL ramp_dir: got %b want 0", motor_dir); end
                cmp++; if (at_target !== (e == 4'd8)) begin err++; $display("FAIL ramp_at_target: got %b want %b at duty %0d", at_target, e == 4'd8, e); end
                prev = duty_cycle; k = 0; first = 1'b0;
            end
        end
        cmp++; if (exp_q.size() != 0) begin err++; $display("FAIL ramp_timeout: %0d steps outstanding want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reverse();
        int zk;
        logic pdir;
        logic [3:0] prev, e;
        for (int i = 7; i >= 0; i--) exp_q.push_back(4'(i));
        for (int i = 1; i <= 5; i++) exp_q.push_back(4'(i));
        send(4'd5, 1'b1);
        prev = duty_cycle; pdir = motor_dir; zk = -1;
        for (int n = 0; n < 2000 && exp_q.size() > 0; n++) begin
            step_clk();
            if (zk >= 0) zk++;
            if (motor_dir !== pdir) begin
                cmp++; if (duty_cycle !== 4'd0 || zk != 32) begin err++; $display("FAIL dead_flip: duty %0d after %0d clocks at 0, want duty 0 after 32", duty_cycle, zk); end
                cmp++; if (motor_dir !== 1'b1) begin err++; $display("FAIL dead_dir: got %b want 1", motor_dir); end
                pdir = motor_dir;
            end
            if (duty_cycle !== prev) begin
                e = exp_q.pop_front();
                cmp++; if (duty_cycle !== e) begin err++; $display("FAIL reverse_duty: got %0d want %0d", duty_cycle, e); end
                cmp++; if (pc != 0) begin err++; $display("FAIL reverse_align: period phase %0d want 0", pc); end
                if (duty_cycle === 4'd0) zk = 0;
                prev = duty_cycle;
            end
        end
        cmp++; if (exp_q.size() != 0) begin err++; $display("FAIL reverse_timeout: %0d steps outstanding want 0", exp_q.size()); end
        cmp++; if (motor_dir !== 1'b1) begin err++; $display("FAIL reverse_final_dir: got %b want 1", motor_dir); end
        cmp++; if (at_target !== 1'b1) begin err++; $display("FAIL reverse_at_target: got %b want 1", at_target); end
        exp_q.delete();
    endtask

    task automatic test_stop_reverse();
        logic [3:0] prev, e;
        reset = 1'b1;
        repeat (2) step_clk();
        reset = 1'b0;
        send(4'd8, 1'b0);
        for (int n = 0; n < 800 && !(duty_cycle === 4'd8 && at_target === 1'b1); n++) step_clk();
        cmp++; if (duty_cycle !== 4'd8) begin err++; $display("FAIL stoprev_setup: got duty %0d want 8", duty_cycle); end
        send(4'd2, 1'b1);
        for (int n = 0; n < 400 && duty_cycle !== 4'd4; n++) step_clk();
        cmp++; if (duty_cycle !== 4'd4) begin err++; $display("FAIL stoprev_reach4: got duty %0d want 4", duty_cycle); end
        for (int i = 5; i <= 10; i++) exp_q.push_back(4'(i));
        send(4'd10, 1'b0);
        prev = duty_cycle;
        for (int n = 0; n < 800 && exp_q.size() > 0; n++) begin
            step_clk();
            if (duty_cycle !== prev) begin
                e = exp_q.pop_front();
                cmp++; if (duty_cycle !== e) begin err++; $display("FAIL stoprev_duty: got %0d want %0d", duty_cycle, e); end
                cmp++; if (pc != 0) begin err++; $display("FAIL stoprev_align: period phase %0d want 0", pc); end
                cmp++; if (motor_dir !== 1'b0) begin err++; $display("FAIL stoprev_dir: got %b want 0", motor_dir); end
                prev = duty_cycle;
            end
        end
        cmp++; if (exp_q.size() != 0) begin err++; $display("FAIL stoprev_timeout: %0d steps outstanding want 0", exp_q.size()); end
        cmp++; if (at_target !== 1'b1) begin err++; $display("FAIL stoprev_at_target: got %b want 1", at_target); end
        exp_q.delete();
    endtask

    task automatic test_estop();
        int changes;
        send(4'd0, 1'b0);
        for (int n = 0; n < 400 && duty_cycle !== 4'd6; n++) step_clk();
        cmp++; if (duty_cycle !== 4'd6) begin err++; $display("FAIL estop_setup: got duty %0d want 6", duty_cycle); end
        estop = 1'b1;
        step_clk();
        cmp++; if (duty_cycle !== 4'd0) begin err++; $display("FAIL estop_duty: got %0d want 0", duty_cycle); end
        cmp++; if (bus.cmd_ready !== 1'b0) begin err++; $display("FAIL estop_ready1: got %b want 0", bus.cmd_ready); end
        step_clk();
        cmp++; if (bus.cmd_ready !== 1'b0) begin err++; $display("FAIL estop_ready2: got %b want 0", bus.cmd_ready); end
        step_clk();
        estop = 1'b0;
        cmp++; if (bus.cmd_ready !== 1'b0) begin err++; $display("FAIL estop_ready3: got %b want 0", bus.cmd_ready); end
        step_clk();
        cmp++; if (bus.cmd_ready !== 1'b1) begin err++; $display("FAIL estop_release_ready: got %b want 1", bus.cmd_ready); end
        cmp++; if (at_target !== 1'b1) begin err++; $display("FAIL estop_at_target: got %b want 1", at_target); end
        changes = 0;
        for (int n = 0; n < 200; n++) begin
            step_clk();
            if (duty_cycle !== 4'd0) changes++;
        end
        cmp++; if (changes != 0) begin err++; $display("FAIL estop_hold: %0d cycles with nonzero duty want 0", changes); end
    endtask

    task automatic test_estop_with_cmd();
        int changes;
        logic [3:0] prev, e;
        bus.cmd_valid = 1'b1; bus.cmd_duty = 4'd9; bus.cmd_dir = 1'b0;
        estop = 1'b1;
        step_clk();
        bus.cmd_valid = 1'b0;
        repeat (2) step_clk();
        estop = 1'b0;
        step_clk();
        changes = 0;
        for (int n = 0; n < 150; n++) begin
            step_clk();
            if (duty_cycle !== 4'd0) changes++;
        end
        cmp++; if (changes != 0) begin err++; $display("FAIL discard_hold: %0d cycles with nonzero duty want 0", changes); end
        cmp++; if (at_target !== 1'b1) begin err++; $display("FAIL discard_at_target: got %b want 1", at_target); end
        for (int i = 1; i <= 3; i++) exp_q.push_back(4'(i));
        send(4'd14, 1'b0);
        send(4'd3, 1'b0);
        prev = duty_cycle;
        for (int n = 0; n < 500 && exp_q.size() > 0; n++) begin
            step_clk();
            if (duty_cycle !== prev) begin
                e = exp_q.pop_front();
                cmp++; if (duty_cycle !== e) begin err++; $display("FAIL b2b_duty: got %0d want %0d", duty_cycle, e); end
                prev = duty_cycle;
            end
        end
        cmp++; if (exp_q.size() != 0) begin err++; $display("FAIL b2b_timeout: %0d steps outstanding want 0", exp_q.size()); end
        repeat (100) step_clk();
        cmp++; if (duty_cycle !== 4'd3) begin err++; $display("FAIL b2b_final: got %0d want 3", duty_cycle); end
        cmp++; if (at_target !== 1'b1) begin err++; $display("FAIL b2b_at_target: got %b want 1", at_target); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int changes;
        send(4'd9, 1'b1);
        for (int n = 0; n < 1500 && !(duty_cycle === 4'd7 && motor_dir === 1'b1); n++) step_clk();
        cmp++; if (duty_cycle !== 4'd7 || motor_dir !== 1'b1) begin err++; $display("FAIL rstmid_setup: got duty %0d dir %b want 7/1", duty_cycle, motor_dir); end
        reset = 1'b1;
        step_clk();
        cmp++; if (duty_cycle !== 4'd0) begin err++; $display("FAIL rstmid_duty: got %0d want 0", duty_cycle); end
        cmp++; if (motor_dir !== 1'b0) begin err++; $display("FAIL rstmid_dir: got %b want 0", motor_dir); end
        cmp++; if (at_target !== 1'b1) begin err++; $display("FAIL rstmid_at_target: got %b want 1", at_target); end
        cmp++; if (bus.cmd_ready !== 1'b0) begin err++; $display("FAIL rstmid_ready: got %b want 0", bus.cmd_ready); end
        reset = 1'b0;
        changes = 0;
        for (int n = 0; n < 200; n++) begin
            step_clk();
            if (duty_cycle !== 4'd0) changes++;
        end
        cmp++; if (changes != 0) begin err++; $display("FAIL rstmid_hold: %0d cycles with nonzero duty want 0", changes); end
    endtask

    initial begin
        cmp = 0; err = 0; pc = 0;
        reset = 1'b1; estop = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_duty = 4'd0; bus.cmd_dir = 1'b0;
        test_reset();
        test_ramp();
        test_reverse();
        test_stop_reverse();
        test_estop();
        test_estop_with_cmd();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
